im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Boot-time writer for the 16-bit instruction memory. Takes bytes from the UART receiver, assembles
//  a framed program image into 16-bit words and issues one write per word at consecutive addresses
//  from 0. Holds the CPU in reset while loading, then releases it. Sits between UART RX and the IM write port.
// PARAMETERS
//  MEM_DEPTH    16384      instruction words available; larger word counts are rejected
//  TIMEOUT_CYC  5_000_000  max clk cycles between bytes inside a frame before abort
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  rx_rdy     in   1   one-cycle strobe: rx_data valid
//  rx_data    in   8   received byte
//  im_we      out  1   one-cycle IM write strobe
//  im_waddr   out  16  IM write address
//  im_wdata   out  16  IM write data
//  cpu_hold   out  1   high: CPU held in reset
//  busy       out  1   frame in progress
//  done       out  1   last frame loaded OK (sticky)
//  err        out  1   last frame aborted (sticky)
// BEHAVIOUR
//  - Reset: state IDLE; im_we=0, im_waddr=0, im_wdata=0, busy=0, done=0, err=0, cpu_hold=1. Reset mid-frame abandons it.
//  - Frame: SYNC(0xA5), CNT_HI, CNT_LO, then 2*N data bytes, high byte first; N = {CNT_HI,CNT_LO}.
//  - FSM: IDLE -> CNT_HI on 0xA5 (other bytes ignored) -> CNT_LO -> DAT_HI <-> DAT_LO -> DONE | ERR.
//  - Transitions advance only on rx_rdy. In IDLE, DONE or ERR, 0xA5 starts a new frame: clears done/err, sets busy/cpu_hold.
//  - CNT_LO: N > MEM_DEPTH -> ERR. N == 0 -> DONE (or CHK, see CONFIGURATION) with no writes.
//  - DAT_LO byte in cycle t: im_we=1 in cycle t+1 with im_wdata={hi,lo} and im_waddr=word index.
//    Index starts at 0 and increments after each write. It never wraps, since N <= MEM_DEPTH.
//  - After write N-1: go to DONE. done=1, busy=0, cpu_hold=0 in the cycle after the last im_we.
//  - ERR: err=1, busy=0, cpu_hold stays 1. Words already written stay written.
//  - Timeout: 32-bit counter reloads on every rx_rdy while busy. TIMEOUT_CYC cycles with no byte while busy -> ERR.
//  - rx_rdy in the same cycle as expiry: the byte wins and the counter reloads.
//  - cpu_hold is 1 from reset until the first DONE. It re-asserts on any new SYNC.
// CONFIGURATION
//  IM_LOADER_CHKSUM_EN defined:
//   - One checksum byte C follows the data (state CHK).
//   - DONE if (sum of all data bytes + C) mod 256 == 0, else ERR.
//   - N == 0 still expects C; C must be 0x00.
//   - The timeout applies in CHK.
//  Not defined: no CHK state; DONE directly after the last write.
// STRUCTURE
//  - Package im_loader_pkg: state encoding localparams (IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE, ERR),
//    SYNC_BYTE=8'hA5, word width 16.
//  - One sub-module im_ldr_timer: loadable down-counter with restart (load) input and expired output.
//  - FSM, word assembly and address counter live in im_loader.
// TESTING
//  - Reset, then send A5 00 02 12 34 AB CD -> im_we at addr 0 data 0x1234, then addr 1 data 0xABCD.
//    Then done=1, cpu_hold=0, err=0.
//  - Send 00 FF A5 00 01 BE EF -> leading bytes ignored; single write addr 0 data 0xBEEF; done=1.
//  - Send A5 40 01 (N=16385 > MEM_DEPTH) -> err=1 with no im_we; cpu_hold=1.
//  - Send A5 00 02 11 22 33, then idle TIMEOUT_CYC cycles -> one write (addr 0, 0x1122), then err=1.
//    Then a valid frame -> done=1, err=0.
//  - Assert rst mid-frame after A5 00 03 01 -> all outputs at reset values.
//    Next frame writes start at addr 0.
//  - CHKSUM_EN: A5 00 01 01 02 FD -> write addr 0 data 0x0102, done=1. Same frame with FE -> err=1 after the write.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the UART-to-instruction-memory boot loader.
// The optional trailing checksum byte is enabled by IM_LOADER_CHKSUM_EN.
package im_loader_pkg;

  localparam int         WORD_W    = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DAT_HI,
    ST_DAT_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  // States between SYNC and the end of a frame: the inter-byte timeout is armed here.
  function automatic logic in_frame(input state_e s);
    return s inside {ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO, ST_CHK};
  endfunction

endpackage

// File: rtl/im_ldr_timer.sv
// Inter-byte watchdog: reloadable down-counter that flags expiry while enabled.
// Expires on the LOAD_VAL-th consecutive cycle without a load.
module im_ldr_timer #(
  parameter int unsigned LOAD_VAL = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= 32'(LOAD_VAL - 1);
    end else if (r_cnt != 32'd0) begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  assign o_expired = i_en && (r_cnt == 32'd0);

endmodule

// File: rtl/im_loader.sv
// Boot loader: parses SYNC/count/data frames from UART RX into 16-bit IM writes and
// holds the CPU in reset until a frame completes. IM_LOADER_CHKSUM_EN adds a checksum byte.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int MEM_DEPTH   = 16384,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              im_we,
  output logic [15:0]       im_waddr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IM_LOADER_CHKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHK;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  state_e            r_state;
  logic [7:0]        r_cnt_hi;
  logic [7:0]        r_hi;
  logic [15:0]       r_count;
  logic [15:0]       r_idx;
  logic              r_we;
  logic [15:0]       r_waddr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [15:0]       w_n;
  logic              w_in_frame;
  logic              w_expired;

  assign w_n        = {r_cnt_hi, rx_data};
  assign w_in_frame = in_frame(r_state);

  im_ldr_timer #(
    .LOAD_VAL (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (rx_rdy | ~w_in_frame),
    .i_en      (w_in_frame),
    .o_expired (w_expired)
  );

`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || !w_in_frame) begin
      r_sum <= 8'h00;
    end else if (rx_rdy && (r_state == ST_DAT_HI || r_state == ST_DAT_LO)) begin
      r_sum <= r_sum + rx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt_hi <= '0;
      r_hi     <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_hold   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Flags settle one cycle after entering DONE/ERR, i.e. after the final write.
          if (r_state == ST_DONE) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_hold <= 1'b0;
          end
          if (r_state == ST_ERR) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end
          // NOTE: later non-blocking assignments in the same block win, so a new SYNC overrides the flags above.
          if (rx_rdy && rx_data == SYNC_BYTE) begin
            r_state <= ST_CNT_HI;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_CNT_HI: if (rx_rdy) begin
          r_cnt_hi <= rx_data;
          r_state  <= ST_CNT_LO;
        end
        ST_CNT_LO: if (rx_rdy) begin
          r_count <= w_n;
          if (int'(w_n) > MEM_DEPTH) r_state <= ST_ERR;
          else if (w_n == 16'd0)     r_state <= ST_AFTER_DATA;
          else                       r_state <= ST_DAT_HI;
        end
        ST_DAT_HI: if (rx_rdy) begin
          r_hi    <= rx_data;
          r_state <= ST_DAT_LO;
        end
        ST_DAT_LO: if (rx_rdy) begin
          r_we    <= 1'b1;
          r_waddr <= r_idx;
          r_wdata <= {r_hi, rx_data};
          r_idx   <= r_idx + 16'd1;
          r_state <= (r_idx == r_count - 16'd1) ? ST_AFTER_DATA : ST_DAT_HI;
        end
`ifdef IM_LOADER_CHKSUM_EN
        ST_CHK: if (rx_rdy) begin
          r_state <= (8'(r_sum + rx_data) == 8'h00) ? ST_DONE : ST_ERR;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (!rx_rdy && w_expired) r_state <= ST_ERR;
    end
  end

  assign im_we    = r_we;
  assign im_waddr = r_waddr;
  assign im_wdata = r_wdata;
  assign cpu_hold = r_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: byte-level frame model checked every cycle, directed frames with
// literal expectations, then randomized frames. Honors IM_LOADER_CHKSUM_EN.
module tb_im_loader;

  localparam int MEM_DEPTH = 16384;
  localparam int TMO       = 48;
`ifdef IM_LOADER_CHKSUM_EN
  localparam bit HAS_CHK = 1'b1;
`else
  localparam bit HAS_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        im_we;
  logic [15:0] im_waddr;
  logic [15:0] im_wdata;
  logic        cpu_hold, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  im_loader #(
    .MEM_DEPTH   (MEM_DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (byte-position arithmetic) ----------------
  bit          m_valid = 1'b0;
  bit          m_we, m_busy, m_done, m_err, m_hold;
  logic [15:0] m_addr, m_data;
  bit          f_active, pend_done, pend_err;
  int          f_pos, f_n, idle_cnt;
  logic [7:0]  f_nhi, f_hi, f_sum;

  task automatic model_end(input bit ok);
    f_active  = 1'b0;
    pend_done = ok;
    pend_err  = !ok;
  endtask

  always @(posedge clk) begin
    m_we = 1'b0;
    if (rst) begin
      m_valid = 1'b1; m_addr = 16'h0; m_data = 16'h0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
      f_active = 1'b0; pend_done = 1'b0; pend_err = 1'b0; idle_cnt = 0;
    end else begin
      if (pend_done) begin m_done = 1'b1; m_busy = 1'b0; m_hold = 1'b0; end
      if (pend_err)  begin m_err  = 1'b1; m_busy = 1'b0; end
      pend_done = 1'b0;
      pend_err  = 1'b0;
      if (rx_rdy) begin
        idle_cnt = 0;
        if (!f_active) begin
          if (rx_data == 8'hA5) begin
            f_active = 1'b1; f_pos = 0; f_sum = 8'h00;
            m_busy = 1'b1; m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
          end
        end else begin
          if (f_pos == 0) f_nhi = rx_data;
          else if (f_pos == 1) begin
            f_n = {f_nhi, rx_data};
            if (f_n > MEM_DEPTH)          model_end(1'b0);
            else if (f_n == 0 && !HAS_CHK) model_end(1'b1);
          end else if (f_pos - 2 < 2 * f_n) begin
            f_sum += rx_data;
            if ((f_pos - 2) % 2 == 0) f_hi = rx_data;
            else begin
              m_we = 1'b1; m_addr = 16'((f_pos - 3) / 2); m_data = {f_hi, rx_data};
            end
            if (f_pos - 2 == 2 * f_n - 1 && !HAS_CHK) model_end(1'b1);
          end else begin
            model_end(8'(f_sum + rx_data) == 8'h00);
          end
          f_pos++;
        end
      end else if (f_active) begin
        idle_cnt++;
        if (idle_cnt >= TMO) model_end(1'b0);
      end
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  logic [31:0] wlog[$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("ctl{we,busy,done,err,hold}", {27'd0, im_we, busy, done, err, cpu_hold},
            {27'd0, m_we, m_busy, m_done, m_err, m_hold});
      if (m_we) check("wr{addr,data}", {im_waddr, im_wdata}, {m_addr, m_data});
    end
    if (im_we === 1'b1) wlog.push_back({im_waddr, im_wdata});
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = -1);
    rx_rdy = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_rdy = 1'b0; rx_data = 8'h00;
    idle(gap < 0 ? int'($urandom_range(2, 5)) : gap);
  endtask

  task automatic send_frame(input logic [7:0] d[$], input logic [7:0] chk_xor);
    logic [7:0] s;
    int n;
    s = 8'h00;
    n = d.size() / 2;
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (d[i]) begin send_byte(d[i]); s += d[i]; end
    if (HAS_CHK) send_byte(8'(-s) ^ chk_xor);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   {31'd0, im_we}, 32'd0);
    check({tag, "_addr"}, {16'd0, im_waddr}, 32'd0);
    check({tag, "_data"}, {16'd0, im_wdata}, 32'd0);
    check({tag, "_flags{busy,done,err,hold}"}, {28'd0, busy, done, err, cpu_hold}, 32'h1);
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp_bdeh);
    check({tag, "_flags{busy,done,err,hold}"}, {28'd0, busy, done, err, cpu_hold}, {28'd0, exp_bdeh});
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d[$];
    int kind, n, cut;

    idle(2);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Two-word frame.
    wlog.delete();
    send_frame('{8'h12, 8'h34, 8'hAB, 8'hCD}, 8'h00);
    idle(4);
    check("f1_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("f1_w0", wlog[0], 32'h0000_1234);
      check("f1_w1", wlog[1], 32'h0001_ABCD);
    end
    check_flags("f1", 4'b0100);

    // Leading noise ignored, single word.
    wlog.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame('{8'hBE, 8'hEF}, 8'h00);
    idle(4);
    check("f2_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("f2_w0", wlog[0], 32'h0000_BEEF);
    check_flags("f2", 4'b0100);

    // Oversize count rejected without writes.
    wlog.delete();
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h01);
    idle(4);
    check("f3_nwr", wlog.size(), 0);
    check_flags("f3", 4'b0011);

    // Count equal to zero: no writes.
    wlog.delete();
    send_frame('{}, 8'h00);
    idle(4);
    check("f4_nwr", wlog.size(), 0);
    check_flags("f4", 4'b0100);

    // Truncated frame times out after one write, then recovery.
    wlog.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 0);
    idle(TMO + 4);
    check("f5_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("f5_w0", wlog[0], 32'h0000_1122);
    check_flags("f5_tmo", 4'b0011);
    send_frame('{8'h55, 8'h66}, 8'h00);
    idle(4);
    check_flags("f5_rec", 4'b0100);

    // Byte arriving in the expiry cycle wins; one cycle later loses.
    wlog.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01, TMO - 1);
    send_byte(8'h12, TMO - 1); send_byte(8'h34, TMO - 1);
    if (HAS_CHK) send_byte(8'hBA);
    idle(4);
    check("f6_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("f6_w0", wlog[0], 32'h0000_1234);
    check_flags("f6_edge", 4'b0100);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01, TMO);
    send_byte(8'h12);
    idle(4);
    check_flags("f6_late", 4'b0011);

    // Reset mid-frame; next frame starts at address 0.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
    do_reset();
    check_reset_outputs("midrst");
    wlog.delete();
    send_frame('{8'h77, 8'h88}, 8'h00);
    idle(4);
    check("f7_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("f7_w0", wlog[0], 32'h0000_7788);

`ifdef IM_LOADER_CHKSUM_EN
    wlog.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hFD);
    idle(4);
    check("c1_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("c1_w0", wlog[0], 32'h0000_0102);
    check_flags("c1", 4'b0100);
    wlog.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hFE);
    idle(4);
    check("c2_nwr", wlog.size(), 1);
    check_flags("c2", 4'b0011);
`endif

    // Randomized frames; the per-cycle model comparison does the checking.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 5));
      d.delete();
      n = int'($urandom_range(0, 5));
      for (int i = 0; i < 2 * n; i++) d.push_back(8'($urandom));
      repeat ($urandom_range(0, 2)) send_byte((8'($urandom) == 8'hA5) ? 8'h00 : 8'($urandom));
      case (kind)
        0, 1, 2: send_frame(d, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
        3: begin
          send_byte(8'hA5);
          send_byte(8'($urandom_range(8'h41, 8'hFF)));
          send_byte(8'($urandom));
        end
        4: begin
          cut = int'($urandom_range(0, 2 + 2 * n));
          send_byte(8'hA5);
          if (cut > 0) send_byte(n[15:8]);
          if (cut > 1) send_byte(n[7:0]);
          for (int i = 0; i < cut - 2; i++) send_byte(d[i]);
          idle(TMO + 3);
        end
        default: begin
          send_byte(8'hA5);
          send_byte(8'h00);
          send_byte(8'($urandom_range(1, 4)));
          do_reset();
          idle(1);
        end
      endcase
      idle(3);
    end

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
